// File: rtl/sext_pkg.sv
// Shared constants and types for the sign-extension arbiter slice.
package sext_pkg;

  localparam int SEXT_IN_W  = 9;
  localparam int SEXT_OUT_W = 16;
  localparam int NUM_REQ    = 3;

  typedef enum logic {
    SEXT_M9 = 1'b0,
    SEXT_M6 = 1'b1
  } sext_mode_t;

  localparam logic [1:0] REQ_BRANCH = 2'd0;
  localparam logic [1:0] REQ_AGU    = 2'd1;
  localparam logic [1:0] REQ_ALUIMM = 2'd2;

endpackage

// File: rtl/sext_core.sv
// Combinational 9->16 sign extender: 9-bit field, or 6-bit field in bits [5:0].
module sext_core
  import sext_pkg::*;
(
  input  logic [SEXT_IN_W-1:0]  d,
  input  sext_mode_t            mode,
  output logic [SEXT_OUT_W-1:0] q
);

  always_comb begin
    if (mode == SEXT_M6) q = {{(SEXT_OUT_W-6){d[5]}}, d[5:0]};
    else                 q = {{(SEXT_OUT_W-SEXT_IN_W){d[8]}}, d};
  end

endmodule

// File: rtl/sext_arbiter.sv
// Three-way arbiter sharing one registered sign extender; round-robin by default,
// fixed priority 0 > 1 > 2 when SEXT_ARB_FIXED_PRIO_EN is defined.
module sext_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*9-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [1:0]           rsp_id
);
  import sext_pkg::*;

  logic                  can_accept;
  logic                  handshake;
  logic [NUM_REQ-1:0]    grant;
  logic [1:0]            grant_id;
  logic [1:0]            idx;
  logic                  found;
  logic [SEXT_IN_W-1:0]  sel_data;
  sext_mode_t            sel_mode;
  logic [SEXT_OUT_W-1:0] ext_q;

`ifndef SEXT_ARB_FIXED_PRIO_EN
  logic [1:0] rr_ptr;
`endif

  assign can_accept = !rsp_valid || rsp_ready;
  assign req_ready  = (rst || !can_accept) ? '0 : grant;
  assign handshake  = |req_ready;

  // First valid requester scanning upward from the pointer (or from 0 with fixed priority).
  always_comb begin
    grant    = '0;
    grant_id = REQ_BRANCH;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
`ifdef SEXT_ARB_FIXED_PRIO_EN
      idx = 2'(k);
`else
      idx = 2'((32'(rr_ptr) + k) % unsigned'(NUM_REQ));
`endif
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = SEXT_M9;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*9 +: 9];
        sel_mode = sext_mode_t'(req_mode[i]);
      end
    end
  end

  sext_core u_core (
    .d    (sel_data),
    .mode (sel_mode),
    .q    (ext_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= REQ_BRANCH;
    end else if (handshake) begin
      rsp_valid <= 1'b1;
      rsp_data  <= ext_q;
      rsp_id    <= grant_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifndef SEXT_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= REQ_BRANCH;
    else if (handshake) rr_ptr <= (grant_id == REQ_ALUIMM) ? REQ_BRANCH : grant_id + 2'd1;
  end
`endif

endmodule

// File: tb/tb_sext_arbiter.sv
// Self-checking bench for sext_arbiter: directed plan steps plus randomized traffic
// against a transaction-level reference model.
module tb_sext_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [26:0] req_data;
  logic [2:0]  req_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_data;
  int          m_id;
  int          m_acc;   // id accepted at the last edge, -1 if none

  logic [8:0] d [3];
  logic [15:0] hold_data;
  logic [1:0]  hold_id;

  sext_arbiter #(.NUM_REQ(3), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sign extension as two's-complement arithmetic on the field value
  function automatic logic [15:0] ext(input logic [8:0] f, input logic m);
    int v;
    if (m) v = (int'(f[5:0]) >= 32) ? int'(f[5:0]) - 64 : int'(f[5:0]);
    else   v = (int'(f) >= 256) ? int'(f) - 512 : int'(f);
    return 16'(v);
  endfunction

  function automatic int pick();
    int j;
    for (int k = 0; k < 3; k++) begin
      j = (m_ptr + k) % 3;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int j;
    logic [2:0] r;
    r = 3'b000;
    if (!rst && (!m_valid || rsp_ready)) begin
      j = pick();
      if (j >= 0) r[j] = 1'b1;
    end
    return r;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [8:0] a0, input logic [8:0] a1,
                       input logic [8:0] a2, input logic [2:0] m, input logic rr);
    req_valid = v;
    d[0] = a0; d[1] = a1; d[2] = a2;
    req_data  = {a2, a1, a0};
    req_mode  = m;
    rsp_ready = rr;
  endtask

  // One clock: check req_ready before the edge, advance model, check outputs after.
  task automatic cycle();
    logic [2:0] er;
    int j;
    #1;
    er = exp_ready();
    chk("req_ready", {29'd0, req_ready}, {29'd0, er});
    @(posedge clk);
    m_acc = -1;
    if (rst) begin
      m_valid = 1'b0; m_data = 16'h0000; m_id = 0; m_ptr = 0;
    end else if (er != 3'b000) begin
      j = (er[0]) ? 0 : (er[1]) ? 1 : 2;
      m_acc   = j;
      m_valid = 1'b1;
      m_data  = ext(d[j], req_mode[j]);
      m_id    = j;
`ifndef SEXT_ARB_FIXED_PRIO_EN
      m_ptr   = (j + 1) % 3;
`endif
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_data",  {16'd0, rsp_data},  {16'd0, m_data});
    chk("rsp_id",    {30'd0, rsp_id},    32'(m_id));
  endtask

  initial begin
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_acc = -1;
    rst = 1'b1;
    drive(3'b111, 9'h1, 9'h2, 9'h3, 3'b000, 1'b1);
    cycle();
    cycle();
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;

    // Requester 0, 9-bit mode
    drive(3'b001, 9'h100, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();
    chk("r0_neg", {16'd0, rsp_data}, 32'h0000FF00);
    chk("r0_id", {30'd0, rsp_id}, 32'd0);
    drive(3'b001, 9'h0FF, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();
    chk("r0_pos", {16'd0, rsp_data}, 32'h000000FF);

    // Requester 2, 6-bit mode; upper field bits ignored
    drive(3'b100, 9'h0, 9'h0, 9'b111_100000, 3'b100, 1'b1);
    cycle();
    chk("r2_m6_neg", {16'd0, rsp_data}, 32'h0000FFE0);
    chk("r2_id", {30'd0, rsp_id}, 32'd2);
    drive(3'b100, 9'h0, 9'h0, 9'b111_011111, 3'b100, 1'b1);
    cycle();
    chk("r2_m6_pos", {16'd0, rsp_data}, 32'h0000001F);

    drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();

    // All three valid continuously
    drive(3'b111, 9'h011, 9'h022, 9'h1F0, 3'b010, 1'b1);
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
`ifdef SEXT_ARB_FIXED_PRIO_EN
      chk("b2b_id", {30'd0, rsp_id}, 32'd0);
`else
      chk("b2b_id", {30'd0, rsp_id}, 32'(n % 3));
`endif
    end

    drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();

    // Stall with a pending result, then release
    drive(3'b001, 9'h155, 9'h0, 9'h0, 3'b000, 1'b0);
    cycle();
    hold_data = rsp_data;
    hold_id   = rsp_id;
    drive(3'b110, 9'h0, 9'h0AA, 9'h123, 3'b000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      #1 chk("stall_ready", {29'd0, req_ready}, 32'd0);
      cycle();
      chk("stall_data", {16'd0, rsp_data}, {16'd0, hold_data});
      chk("stall_id", {30'd0, rsp_id}, {30'd0, hold_id});
    end
    rsp_ready = 1'b1;
    #1 chk("release_ready", {29'd0, req_ready}, 32'b010);
    cycle();
    chk("release_id", {30'd0, rsp_id}, 32'd1);

    // Reset while a result is pending and requests are waiting
    drive(3'b111, 9'h1, 9'h2, 9'h3, 3'b000, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_data", {16'd0, rsp_data}, 32'd0);
    chk("midrst_id", {30'd0, rsp_id}, 32'd0);
    rst = 1'b0;
    drive(3'b110, 9'h0, 9'h081, 9'h3, 3'b000, 1'b1);
    cycle();
    chk("post_rst_id", {30'd0, rsp_id}, 32'd1);

    // Idle, then requester 1 alone, then requester 0 after the wrap
    drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 1'b1);
    for (int n = 0; n < 5; n++) cycle();
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    drive(3'b010, 9'h0, 9'h07F, 9'h0, 3'b000, 1'b1);
    cycle();
    chk("solo1_id", {30'd0, rsp_id}, 32'd1);
    drive(3'b001, 9'h1FF, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();
    chk("wrap0_id", {30'd0, rsp_id}, 32'd0);
    chk("wrap0_data", {16'd0, rsp_data}, 32'h0000FFFF);

    // Randomized traffic; requesters hold their request until accepted
    drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 1'b1);
    cycle();
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  v;
      logic [2:0]  m;
      logic [8:0]  nd [3];
      v = req_valid; m = req_mode;
      for (int i = 0; i < 3; i++) begin
        nd[i] = d[i];
        if (m_acc == i) v[i] = 1'b0;
        if (!v[i] && ($urandom_range(0, 3) != 0)) begin
          v[i]  = 1'b1;
          nd[i] = 9'($urandom);
          m[i]  = 1'($urandom);
        end
      end
      drive(v, nd[0], nd[1], nd[2], m, 1'($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
